// File: rtl/motion_pkg.sv
// motion_pkg
// Shared definitions for the motion centroid tracker slice.
//   - width helpers derived from the frame geometry
//   - default widths for a 160x120 frame
//   - tracker FSM state encoding
package motion_pkg;

  // Pixel coordinate width for a dimension of the given size.
  function automatic int xw_of(input int pixels);
    return $clog2(pixels);
  endfunction

  // Motion counter width: must hold every pixel of the frame.
  function automatic int cw_of(input int h_pixels, input int v_pixels);
    return $clog2(h_pixels * v_pixels + 1);
  endfunction

  // Coordinate sum width: a full frame of maximal x values still fits.
  function automatic int sw_of(input int h_pixels, input int v_pixels);
    return xw_of(h_pixels) + cw_of(h_pixels, v_pixels);
  endfunction

  localparam int DEF_XW = xw_of(160);
  localparam int DEF_YW = xw_of(120);
  localparam int DEF_CW = cw_of(160, 120);
  localparam int DEF_SW = sw_of(160, 120);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/motion_centroid_tracker_if.sv
// motion_centroid_tracker_if
// Pixel stream in, per-frame tracking results out.
//   pixel side : pix_valid, pix_x, pix_y, motion_flag, frame_end
//   result side: com_x/com_y, bbox_x0/x1/y0/y1, motion_count,
//                out_valid, tracking, overrun
// master = pixel source / overlay consumer, slave = tracker.
interface motion_centroid_tracker_if #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120
);
  localparam int XW = motion_pkg::xw_of(H_PIXELS);
  localparam int YW = motion_pkg::xw_of(V_PIXELS);
  localparam int CW = motion_pkg::cw_of(H_PIXELS, V_PIXELS);

  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          motion_flag;
  logic          frame_end;

  logic [XW-1:0] com_x;
  logic [YW-1:0] com_y;
  logic [XW-1:0] bbox_x0;
  logic [XW-1:0] bbox_x1;
  logic [YW-1:0] bbox_y0;
  logic [YW-1:0] bbox_y1;
  logic [CW-1:0] motion_count;
  logic          out_valid;
  logic          tracking;
  logic          overrun;

  modport master (
    output pix_valid, pix_x, pix_y, motion_flag, frame_end,
    input  com_x, com_y, bbox_x0, bbox_x1, bbox_y0, bbox_y1,
    input  motion_count, out_valid, tracking, overrun
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, motion_flag, frame_end,
    output com_x, com_y, bbox_x0, bbox_x1, bbox_y0, bbox_y1,
    output motion_count, out_valid, tracking, overrun
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
// Restoring unsigned divider, one quotient bit per cycle.
//   clk, reset (async, active low)
//   start    : loads dividend/divisor, ignored while busy
//   busy     : high for exactly DW cycles after start
//   done     : pulses in the last busy cycle; quotient is final from the
//              next cycle on and held until the next start
//   quotient : floor(dividend / divisor); divisor must be non-zero
module seq_divider #(
  parameter int DW = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);
  localparam int STW = $clog2(DW + 1);

  logic [DW-1:0]  rem_q;
  logic [DW-1:0]  quo_q;
  logic [DW-1:0]  dvs_q;
  logic [STW-1:0] step_q;
  logic           busy_q;

  logic [DW:0] trial;
  logic [DW:0] reduced;
  logic        fits;
  logic        unused_msb;

  // The dividend is shifted out of quo_q MSB-first into the partial
  // remainder while quotient bits shift in at the bottom.
  always_comb begin
    trial   = {rem_q, quo_q[DW-1]};
    fits    = (trial >= {1'b0, dvs_q});
    reduced = trial - {1'b0, dvs_q};
  end

  assign unused_msb = reduced[DW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      step_q <= STW'(DW);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= fits ? reduced[DW-1:0] : trial[DW-1:0];
      quo_q  <= {quo_q[DW-2:0], fits};
      step_q <= step_q - STW'(1);
      if (step_q == STW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (step_q == STW'(1));
  assign quotient = quo_q;
endmodule

// File: rtl/motion_centroid_tracker.sv
// motion_centroid_tracker
// Accumulates motion pixels per frame, divides for the centroid at frame
// end, IIR-smooths it and tracks lock/loss across frames.
//   clk   : camera pixel clock
//   reset : async, active low
//   bus   : slave side of motion_centroid_tracker_if (pixel stream in,
//           centroid/bbox/count/status out)
module motion_centroid_tracker
  import motion_pkg::*;
#(
  parameter int H_PIXELS     = 160,
  parameter int V_PIXELS     = 120,
  parameter int MIN_COUNT    = 16,
  parameter int HOLD_FRAMES  = 3,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic clk,
  input  logic reset,
  motion_centroid_tracker_if.slave bus
);
  localparam int XW = xw_of(H_PIXELS);
  localparam int YW = xw_of(V_PIXELS);
  localparam int CW = cw_of(H_PIXELS, V_PIXELS);
  localparam int SW = sw_of(H_PIXELS, V_PIXELS);
  localparam int MW = $clog2(HOLD_FRAMES + 1);

  state_t state_q, state_d;

  logic [CW-1:0] acc_cnt, cnt_upd;
  logic [SW-1:0] acc_sum_x, sum_x_upd, acc_sum_y, sum_y_upd;
  logic [XW-1:0] acc_x0, acc_x1, x0_upd, x1_upd;
  logic [YW-1:0] acc_y0, acc_y1, y0_upd, y1_upd;
  logic          hit;

  logic [CW-1:0] frame_cnt;
  logic [XW-1:0] frame_x0, frame_x1;
  logic [YW-1:0] frame_y0, frame_y1;
  logic          frame_valid;

  logic          div_start, done_x, done_y, busy_x, busy_y;
  logic [SW-1:0] quo_x, quo_y;

  logic [XW-1:0] com_x_q, bbox_x0_q, bbox_x1_q, smooth_x;
  logic [YW-1:0] com_y_q, bbox_y0_q, bbox_y1_q, smooth_y;
  logic signed [XW:0] diff_x, step_x;
  logic signed [YW:0] diff_y, step_y;
  logic [CW-1:0] motion_count_q;
  logic [MW-1:0] miss_cnt, miss_nxt;
  logic          out_valid_q, tracking_q, overrun_q, first_lock;
  logic          unused_bits;

  // Running frame statistics including the current pixel. These are also
  // what a frame_end snapshots, so a pixel coincident with frame_end
  // lands in the closing frame.
  always_comb begin
    hit = bus.pix_valid && bus.motion_flag &&
          ({1'b0, bus.pix_x} < (XW+1)'(H_PIXELS)) &&
          ({1'b0, bus.pix_y} < (YW+1)'(V_PIXELS));
    cnt_upd   = acc_cnt;
    sum_x_upd = acc_sum_x;
    sum_y_upd = acc_sum_y;
    x0_upd    = acc_x0;
    x1_upd    = acc_x1;
    y0_upd    = acc_y0;
    y1_upd    = acc_y1;
    if (hit) begin
      if (acc_cnt != '1) cnt_upd = acc_cnt + CW'(1);
      sum_x_upd = acc_sum_x + SW'(bus.pix_x);
      sum_y_upd = acc_sum_y + SW'(bus.pix_y);
      if (bus.pix_x < acc_x0) x0_upd = bus.pix_x;
      if (bus.pix_x > acc_x1) x1_upd = bus.pix_x;
      if (bus.pix_y < acc_y0) y0_upd = bus.pix_y;
      if (bus.pix_y > acc_y1) y1_upd = bus.pix_y;
    end
  end

  // Accumulators run regardless of FSM state; frame_end restarts them
  // in the same cycle so the next frame has no gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bus.frame_end) begin
      acc_cnt   <= '0;
      acc_sum_x <= '0;
      acc_sum_y <= '0;
      acc_x0    <= '1;
      acc_x1    <= '0;
      acc_y0    <= '1;
      acc_y1    <= '0;
    end else begin
      acc_cnt   <= cnt_upd;
      acc_sum_x <= sum_x_upd;
      acc_sum_y <= sum_y_upd;
      acc_x0    <= x0_upd;
      acc_x1    <= x1_upd;
      acc_y0    <= y0_upd;
      acc_y1    <= y1_upd;
    end
  end

  // Frame snapshot when idle; otherwise the frame is dropped and flagged.
  // The sums are captured by the dividers themselves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      frame_x0  <= '0;
      frame_x1  <= '0;
      frame_y0  <= '0;
      frame_y1  <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (bus.frame_end) begin
        if (state_q == IDLE) begin
          frame_cnt <= cnt_upd;
          frame_x0  <= x0_upd;
          frame_x1  <= x1_upd;
          frame_y0  <= y0_upd;
          frame_y1  <= y1_upd;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign frame_valid = (frame_cnt >= CW'(MIN_COUNT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Dividers start straight from the frame_end cycle so a measurement
  // frame spends exactly SW cycles in DIV.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_end) begin
          state_d   = DIV;
          div_start = (cnt_upd >= CW'(MIN_COUNT));
        end
      end
      DIV: begin
        if (!frame_valid || (done_x && done_y)) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seq_divider #(.DW(SW)) u_div_x (
    .clk(clk), .reset(reset), .start(div_start),
    .dividend(sum_x_upd), .divisor(SW'(cnt_upd)),
    .busy(busy_x), .done(done_x), .quotient(quo_x)
  );

  seq_divider #(.DW(SW)) u_div_y (
    .clk(clk), .reset(reset), .start(div_start),
    .dividend(sum_y_upd), .divisor(SW'(cnt_upd)),
    .busy(busy_y), .done(done_y), .quotient(quo_y)
  );

  // IIR step: the signed difference is one bit wider than the coordinate,
  // and the smoothed value always lies between old com and measurement,
  // so modular addition in XW/YW bits is exact.
  always_comb begin
    diff_x   = $signed({1'b0, quo_x[XW-1:0]}) - $signed({1'b0, com_x_q});
    diff_y   = $signed({1'b0, quo_y[YW-1:0]}) - $signed({1'b0, com_y_q});
    step_x   = diff_x >>> SMOOTH_SHIFT;
    step_y   = diff_y >>> SMOOTH_SHIFT;
    smooth_x = com_x_q + step_x[XW-1:0];
    smooth_y = com_y_q + step_y[YW-1:0];
    miss_nxt = (miss_cnt >= MW'(HOLD_FRAMES)) ? MW'(HOLD_FRAMES)
                                              : miss_cnt + MW'(1);
  end

  assign unused_bits = ^{busy_x, busy_y, quo_x[SW-1:XW], quo_y[SW-1:YW],
                         step_x[XW], step_y[YW]};

  // Result registers; out_valid rises together with the new values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      com_x_q        <= '0;
      com_y_q        <= '0;
      bbox_x0_q      <= '0;
      bbox_x1_q      <= '0;
      bbox_y0_q      <= '0;
      bbox_y1_q      <= '0;
      motion_count_q <= '0;
      out_valid_q    <= 1'b0;
      tracking_q     <= 1'b0;
      miss_cnt       <= '0;
      first_lock     <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == UPDATE) begin
        out_valid_q    <= 1'b1;
        motion_count_q <= frame_cnt;
        if (frame_valid) begin
          miss_cnt   <= '0;
          tracking_q <= 1'b1;
          bbox_x0_q  <= frame_x0;
          bbox_x1_q  <= frame_x1;
          bbox_y0_q  <= frame_y0;
          bbox_y1_q  <= frame_y1;
          first_lock <= 1'b0;
          com_x_q    <= first_lock ? quo_x[XW-1:0] : smooth_x;
          com_y_q    <= first_lock ? quo_y[YW-1:0] : smooth_y;
        end else begin
          miss_cnt <= miss_nxt;
          if (miss_nxt == MW'(HOLD_FRAMES)) begin
            tracking_q <= 1'b0;
            first_lock <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.com_x        = com_x_q;
  assign bus.com_y        = com_y_q;
  assign bus.bbox_x0      = bbox_x0_q;
  assign bus.bbox_x1      = bbox_x1_q;
  assign bus.bbox_y0      = bbox_y0_q;
  assign bus.bbox_y1      = bbox_y1_q;
  assign bus.motion_count = motion_count_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.tracking     = tracking_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_motion_centroid_tracker.sv
// tb_motion_centroid_tracker
// Directed bench for motion_centroid_tracker on a 160x120 frame with
// MIN_COUNT=16, HOLD_FRAMES=3, SMOOTH_SHIFT=2 (sum width 23, so a
// measurement frame reports 25 cycles after frame_end).
module tb_motion_centroid_tracker;
  localparam int H  = 160;
  localparam int V  = 120;
  localparam int XW = motion_pkg::xw_of(H);
  localparam int YW = motion_pkg::xw_of(V);
  localparam int LAT_MEAS = motion_pkg::sw_of(H, V) + 2;
  localparam int LAT_MISS = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int tests    = 0;
  int failures = 0;

  typedef struct {
    int x0, x1, y0, y1;
    int cx, cy, bx0, bx1, by0, by1, cnt, trk, lat;
  } vec_t;

  vec_t vecs[9];

  motion_centroid_tracker_if #(.H_PIXELS(H), .V_PIXELS(V)) bus ();

  motion_centroid_tracker #(
    .H_PIXELS(H), .V_PIXELS(V), .MIN_COUNT(16),
    .HOLD_FRAMES(3), .SMOOTH_SHIFT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of pixel-side inputs, then returns them to idle.
  task automatic applyStimulus(input bit v, input int x, input int y,
                               input bit m, input bit fe);
    bus.pix_valid   = v;
    bus.pix_x       = XW'(x);
    bus.pix_y       = YW'(y);
    bus.motion_flag = m;
    bus.frame_end   = fe;
    tick();
    bus.pix_valid   = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    bus.motion_flag = 1'b0;
    bus.frame_end   = 1'b0;
  endtask

  task automatic sendRect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        applyStimulus(1'b1, x, y, 1'b1, 1'b0);
  endtask

  // Called in the cycle after frame_end; returns that cycle's offset
  // when out_valid is seen, or -1 if it never comes.
  task automatic waitOut(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic checkResult(input string tag, input int cx, input int cy,
                             input int bx0, input int bx1, input int by0,
                             input int by1, input int cnt, input int trk);
    checkOutput({tag, " com_x"}, int'(bus.com_x), cx);
    checkOutput({tag, " com_y"}, int'(bus.com_y), cy);
    checkOutput({tag, " bbox_x0"}, int'(bus.bbox_x0), bx0);
    checkOutput({tag, " bbox_x1"}, int'(bus.bbox_x1), bx1);
    checkOutput({tag, " bbox_y0"}, int'(bus.bbox_y0), by0);
    checkOutput({tag, " bbox_y1"}, int'(bus.bbox_y1), by1);
    checkOutput({tag, " motion_count"}, int'(bus.motion_count), cnt);
    checkOutput({tag, " tracking"}, int'(bus.tracking), trk);
  endtask

  task automatic checkAllZero(input string tag);
    checkResult(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput({tag, " out_valid"}, int'(bus.out_valid), 0);
    checkOutput({tag, " overrun"}, int'(bus.overrun), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int ov_seen;
    int ovalid_seen;
    int ovalid_at;

    vecs[0] = '{10, 19, 20, 29,    14, 24, 10, 19, 20, 29,    100, 1, LAT_MEAS};
    vecs[1] = '{50, 59, 20, 29,    24, 24, 50, 59, 20, 29,    100, 1, LAT_MEAS};
    vecs[2] = '{100, 104, 5, 5,    24, 24, 50, 59, 20, 29,      5, 1, LAT_MISS};
    vecs[3] = '{100, 104, 5, 5,    24, 24, 50, 59, 20, 29,      5, 1, LAT_MISS};
    vecs[4] = '{100, 104, 5, 5,    24, 24, 50, 59, 20, 29,      5, 0, LAT_MISS};
    vecs[5] = '{0, 3, 0, 3,         1,  1,  0,  3,  0,  3,     16, 1, LAT_MEAS};
    vecs[6] = '{0, 14, 0, 0,        1,  1,  0,  3,  0,  3,     15, 1, LAT_MISS};
    vecs[7] = '{0, 3, 100, 103,     1, 26,  0,  3, 100, 103,   16, 1, LAT_MEAS};
    vecs[8] = '{0, 3, 0, 3,         1, 19,  0,  3,  0,  3,     16, 1, LAT_MEAS};

    bus.pix_valid   = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    bus.motion_flag = 1'b0;
    bus.frame_end   = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b1;
    tick();

    // Frame sequence: lock, smoothing, loss after three misses, relock,
    // MIN_COUNT boundary both sides, smoothing in both directions.
    for (int i = 0; i < 9; i++) begin
      sendRect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      waitOut(lat);
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].lat);
      checkResult($sformatf("v%0d", i), vecs[i].cx, vecs[i].cy,
                  vecs[i].bx0, vecs[i].bx1, vecs[i].by0, vecs[i].by1,
                  vecs[i].cnt, vecs[i].trk);
      tick();
      checkOutput($sformatf("v%0d out_valid pulse", i), int'(bus.out_valid), 0);
    end

    // Pixel coincident with frame_end at the far corner belongs to the
    // closing frame; out-of-range, non-motion and invalid pixels ignored.
    sendRect(144, 158, 119, 119);
    applyStimulus(1'b1, 160, 119, 1'b1, 1'b0);
    applyStimulus(1'b1, 159, 120, 1'b1, 1'b0);
    applyStimulus(1'b1, 5, 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 6, 6, 1'b1, 1'b0);
    applyStimulus(1'b1, 159, 119, 1'b1, 1'b1);
    waitOut(lat);
    checkOutput("corner latency", lat, LAT_MEAS);
    checkResult("corner", 38, 44, 144, 159, 119, 119, 16, 1);

    // Second frame_end while the divider is busy: one overrun pulse, only
    // the first frame reports, and pixels of the dropped frame vanish.
    sendRect(10, 19, 20, 29);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    ov_seen = 0;
    ovalid_seen = 0;
    ovalid_at = -1;
    for (int c = 1; c <= 45; c++) begin
      if (bus.overrun) ov_seen++;
      if (bus.out_valid) begin
        ovalid_seen++;
        if (ovalid_at < 0) ovalid_at = c;
      end
      if (c < 10)       applyStimulus(1'b1, c, c, 1'b1, 1'b0);
      else if (c == 10) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      else              tick();
    end
    checkOutput("overrun pulses", ov_seen, 1);
    checkOutput("overrun out_valid count", ovalid_seen, 1);
    checkOutput("overrun latency", ovalid_at, LAT_MEAS);
    checkResult("overrun frame", 32, 39, 10, 19, 20, 29, 100, 1);
    sendRect(0, 3, 0, 3);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    waitOut(lat);
    checkOutput("after overrun latency", lat, LAT_MEAS);
    checkResult("after overrun", 24, 29, 0, 3, 0, 3, 16, 1);

    // Reset while dividing: outputs clear without a clock edge, the
    // aborted frame never reports, and the next frame relocks raw.
    sendRect(10, 19, 20, 29);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    checkAllZero("mid-div reset");
    repeat (2) tick();
    reset = 1'b1;
    ovalid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.out_valid) ovalid_seen++;
    end
    checkOutput("aborted out_valid count", ovalid_seen, 0);
    sendRect(50, 59, 20, 29);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    waitOut(lat);
    checkOutput("post-reset latency", lat, LAT_MEAS);
    checkResult("post-reset", 54, 24, 50, 59, 20, 29, 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/motion_centroid_tracker.md
Name: motion_centroid_tracker

Overview:
Per-frame motion tracker that replaces the free-running centroid logic in the VGA camera path.
- Accumulates motion-flagged pixels from the compare stage over one frame.
- At frame end, computes the centroid and bounding box using a shared serial divider.
- Smooths the position with a programmable IIR filter and tracks lock/loss across frames.
- Feeds com_x/com_y and bbox to the display overlay stage.

Parameters:
H_PIXELS, 160, active frame width; x valid range 0..H_PIXELS-1
V_PIXELS, 120, active frame height; y valid range 0..V_PIXELS-1
MIN_COUNT, 16, minimum motion pixels per frame for a valid measurement
HOLD_FRAMES, 3, consecutive invalid frames before tracking drops
SMOOTH_SHIFT, 2, IIR shift; 0 = raw measurement

Ports:
clk  in  1  single clock domain, camera pclk
reset  in  1  asynchronous, active-low reset
pix_valid  in  1  pixel qualifier
pix_x  in  XW=$clog2(H_PIXELS)  pixel column
pix_y  in  YW=$clog2(V_PIXELS)  pixel row
motion_flag  in  1  pixel differs from previous frame
frame_end  in  1  one-cycle pulse closing the frame
com_x  out  XW  smoothed centroid x
com_y  out  YW  smoothed centroid y
bbox_x0/bbox_x1  out  XW  motion box min/max x, last valid frame
bbox_y0/bbox_y1  out  YW  motion box min/max y, last valid frame
motion_count  out  CW=$clog2(H_PIXELS*V_PIXELS+1)  motion pixels, last closed frame
out_valid  out  1  one-cycle pulse when outputs update
tracking  out  1  target locked
overrun  out  1  one-cycle pulse: frame dropped, divider busy

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM IDLE, accumulators cleared, min regs set to max, max regs set to 0, miss_cnt 0, first-lock flag set.
- Accumulate (every cycle, independent of FSM state):
  - Condition: pix_valid & motion_flag & pix_x<H_PIXELS & pix_y<V_PIXELS.
  - Action: cnt++ (saturating), sum_x+=pix_x, sum_y+=pix_y, update min/max.
  - Out-of-range pixels are ignored.
- Simultaneous pixel and frame_end: the pixel belongs to the closing frame.
- frame_end with FSM IDLE:
  - Snapshot cnt/sums/bbox into frame regs.
  - Clear accumulators in the same cycle; the next frame accumulates without a gap.
  - FSM -> DIV.
- frame_end with FSM not IDLE: snapshot discarded, accumulators cleared, overrun pulses for 1 cycle, FSM unaffected.
- FSM states: IDLE -> DIV -> UPDATE -> IDLE.
  - DIV: if snapshot cnt < MIN_COUNT, skip division and go to UPDATE in 1 cycle. Otherwise start sum_x/cnt and sum_y/cnt on two divider instances in parallel; stay until both done (SW cycles, SW = sum width = XW+CW).
  - UPDATE: 1 cycle; registers results; out_valid pulses in the following cycle.
- Latency: a measurement frame's out_valid occurs exactly SW+2 cycles after its frame_end cycle. A sub-MIN_COUNT frame's out_valid occurs 3 cycles after.
- Quotient: truncating (floor); quotient < H_PIXELS/V_PIXELS by construction; truncate to XW/YW.
- Valid measurement (cnt>=MIN_COUNT):
  - miss_cnt=0 and tracking=1.
  - bbox updated.
  - If first-lock: com = measurement, clear first-lock. Else com = com + ((meas - com) >>> SMOOTH_SHIFT), computed signed in XW+1/YW+1 bits.
- Invalid frame:
  - miss_cnt++ (saturating at HOLD_FRAMES).
  - com and bbox hold.
  - When miss_cnt reaches HOLD_FRAMES: tracking=0 and first-lock set.
- motion_count always updates on out_valid.
- Reset mid-DIV: divider aborted, no out_valid; state as after reset.

Decomposition:
- Package motion_pkg: width functions/localparams (XW, YW, CW, SW), FSM state enum {IDLE, DIV, UPDATE}.
- Sub-module seq_divider #(DW):
  - Restoring, 1 quotient bit per cycle.
  - Handshake: start pulse loads operands; busy high DW cycles; done pulse with quotient.
  - Divisor 0 never issued (guarded by MIN_COUNT>=1).
  - Instantiated twice.

Test Plan:
- Rectangle x10..19, y20..29, all motion, SMOOTH_SHIFT=0, then frame_end -> after SW+2 cycles out_valid=1, com=(14,24), bbox=(10,20)-(19,29), motion_count=100, tracking=1.
- Two frames, same 100-pixel rectangle centred at (14,24) then shifted to centroid (54,24), SMOOTH_SHIFT=2 -> com_x 14 then 24; com_y stays 24.
- 5 motion pixels per frame after lock, HOLD_FRAMES=3 -> 1st/2nd out_valid tracking=1 with com held, 3rd out_valid tracking=0, motion_count=5; next valid frame loads raw centroid.
- Second frame_end 10 cycles after the first (divider busy) -> overrun pulse once; only the first frame produces out_valid; the following frame processes normally.
- Pixel with motion_flag coincident with frame_end at (159,119) -> included: bbox_x1=159, bbox_y1=119.
- reset asserted mid-DIV -> outputs 0 immediately, no out_valid, next frame behaves as first-lock.
